pipeline_control: RTL and testbench
===================================

// Module: pipeline_control
// PURPOSE
//   Drives the writeEnable/flush pins of the four stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
//   Turns hazard and stall requests into per-stage freeze and bubble commands.
//   Sits beside the datapath; every output is a flop, so the asynchronous active-low stage-buffer flush is never glitched.
// PARAMETERS
//   CNT_WIDTH   4   width of multiCycles (multi-cycle EX latency request)
//   STAT_WIDTH  16  width of the stallCycles performance counter
// PORTS
//   clk          in   1          system clock, rising edge
//   resetn       in   1          reset, asynchronous assert, active-low
//   branchTaken  in   1          EX resolved a taken branch/jump this cycle
//   loadUseHaz   in   1          ID needs the result of the load in EX
//   multiStart   in   1          EX starts a multi-cycle op this cycle
//   multiCycles  in   CNT_WIDTH  extra cycles the op needs (0 treated as 1)
//   memReady     in   1          data memory ready; low = stall whole pipe
//   statClear    in   1          synchronous clear of stallCycles
//   pcWE         out  1          PC write enable
//   ifidWE, idexWE, exmemWE, memwbWE              out 1  stage buffer writeEnable
//   ifidFlushN, idexFlushN, exmemFlushN, memwbFlushN  out 1  stage buffer flush, active-low
//   busy         out  1          state != RUN
//   stallCycles  out  STAT_WIDTH cycles spent outside RUN, saturating
// BEHAVIOUR
//   Reset (resetn low, async): state=RUN, counter=0, stallCycles=0, all WE=0, all FlushN=0, busy=0.
//     This holds every stage buffer clear. First edge after release loads RUN outputs.
//   Outputs are a registered Moore decode of the next state: a request sampled at edge k drives outputs from edge k on.
//   RUN: all WE=1, all FlushN=1. Priority at each edge: branchTaken > !memReady > multiStart > loadUseHaz.
//   REDIRECT (from branchTaken): 1 cycle; ifidFlushN=0, idexFlushN=0; other FlushN=1; all WE=1; next RUN.
//     A buffer stays cleared through the closing edge, so the taken-branch penalty is exactly 2 bubbles.
//   STALL_LU (from loadUseHaz): 1 cycle; pcWE=0, ifidWE=0, idexFlushN=0; exmem/memwb WE=1; next RUN.
//     loadUseHaz is ignored while in STALL_LU.
//   MULTI (from multiStart): counter loaded with max(multiCycles,1)-1.
//     pcWE, ifidWE, idexWE, exmemWE = 0; memwbFlushN=0 (bubbles into WB); memwbWE=1.
//     Counter decrements each cycle; at counter==0 next state is MEMWAIT if !memReady, else RUN.
//     branchTaken, loadUseHaz and multiStart are ignored in MULTI; EX is frozen, so they re-present in RUN.
//   MEMWAIT (from !memReady): all WE=0, all FlushN=1; stay while memReady=0; next RUN on the first edge with memReady=1.
//     branchTaken is ignored here, since EX is frozen and it re-presents.
//   Simultaneous requests: the highest priority wins; the rest are dropped, and upstream holds them because the pipe is frozen or flushed.
//   stallCycles: +1 on each edge where the current state != RUN; saturates at all-ones.
//     statClear has priority over the increment (counter goes to 0).
//   Reset mid-MULTI or mid-MEMWAIT: immediate return to the reset values; nothing is retained.
//   State encoding is one-hot-free binary, 2 bits: RUN=0, REDIRECT=1, STALL_LU=2, MULTI=3. MEMWAIT uses a third bit.
//     The encoding is 3 bits total; the illegal codes 5-7 go to RUN.
// STRUCTURE
//   pipeline_ctrl_defs.vh: state codes (ST_RUN, ST_REDIRECT, ST_STALL_LU, ST_MULTI, ST_MEMWAIT) and the per-state output vector constants.
//   Sub-module sat_counter #(WIDTH): saturating up-counter with synchronous clear; used for stallCycles.
//   FSM, latency down-counter and output registers live in this module.
// TESTING
//   Reset: hold resetn=0 3 cycles -> all WE=0, all FlushN=0, stallCycles=0. Release -> next edge all WE=1, FlushN=1.
//   branchTaken 1 cycle in RUN -> one cycle with ifidFlushN=idexFlushN=0, then RUN. stallCycles=1.
//   multiStart with multiCycles=3 -> pcWE/ifid/idex/exmem WE=0 and memwbFlushN=0 for 3 cycles, then RUN. busy high 3 cycles.
//   multiCycles=0 -> 1 stall cycle. multiStart+branchTaken same edge -> REDIRECT only.
//   memReady=0 for 4 cycles starting the last MULTI cycle -> MULTI exits to MEMWAIT.
//     All WE=0 until memReady=1, then RUN. stallCycles counts every non-RUN cycle.
//   resetn pulsed low mid-MULTI -> outputs at reset values without a clock edge.
//   Counter saturation: preload near max (STAT_WIDTH=4 build), 20 stall cycles -> stallCycles=4'hF; statClear -> 0.

Source files
------------

// File: rtl/pipeline_control_pkg.sv
// pipeline_control_pkg
//   Shared definitions for the pipeline controller: FSM state codes and
//   the stage-buffer control vector that goes with each state.
//   Control vector bit order (MSB..LSB):
//     {pcWE, ifidWE, idexWE, exmemWE, memwbWE,
//      ifidFlushN, idexFlushN, exmemFlushN, memwbFlushN}
package pipeline_control_pkg;

    // Binary codes. MEMWAIT takes the third bit. Codes 5-7 are illegal.
    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_REDIRECT = 3'd1,
        ST_STALL_LU = 3'd2,
        ST_MULTI    = 3'd3,
        ST_MEMWAIT  = 3'd4
    } state_t;

    localparam int CTL_W = 9;

    localparam logic [CTL_W-1:0] CTL_RESET    = '0;
    localparam logic [CTL_W-1:0] CTL_RUN      = 9'b11111_1111;
    localparam logic [CTL_W-1:0] CTL_REDIRECT = 9'b11111_0011;
    localparam logic [CTL_W-1:0] CTL_STALL_LU = 9'b00111_1011;
    localparam logic [CTL_W-1:0] CTL_MULTI    = 9'b00001_1110;
    localparam logic [CTL_W-1:0] CTL_MEMWAIT  = 9'b00000_1111;

    function automatic logic [CTL_W-1:0] ctl_of(input state_t s);
        logic [CTL_W-1:0] v;
        case (s)
            ST_REDIRECT: v = CTL_REDIRECT;
            ST_STALL_LU: v = CTL_STALL_LU;
            ST_MULTI:    v = CTL_MULTI;
            ST_MEMWAIT:  v = CTL_MEMWAIT;
            default:     v = CTL_RUN;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pipeline_control_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear (clear wins over increment).
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low reset, counter -> 0
//     i_clear  in   synchronous clear
//     i_inc    in   count enable
//     o_count  out  WIDTH-bit count, sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_control.sv
// pipeline_control
//   Drives writeEnable / active-low flush of the IF/ID, ID/EX, EX/MEM and
//   MEM/WB stage buffers plus the PC write enable, converting hazard and
//   stall requests into per-stage freeze and bubble commands.
//   All outputs are flops (registered Moore decode of the next state), so
//   the asynchronous flush pins never see a glitch.
//   Ports:
//     clk, resetn                 clock / async active-low reset
//     branchTaken                 EX resolved a taken branch
//     loadUseHaz                  ID depends on the load in EX
//     multiStart, multiCycles     EX starts a multi-cycle op (0 treated as 1)
//     memReady                    data memory ready; low freezes the pipe
//     statClear                   synchronous clear of stallCycles
//     pcWE, *WE                   PC / stage buffer write enables
//     *FlushN                     stage buffer flush, active-low
//     busy                        controller not in RUN
//     stallCycles                 saturating count of non-RUN cycles
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int CNT_WIDTH  = 4,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  branchTaken,
    input  logic                  loadUseHaz,
    input  logic                  multiStart,
    input  logic [CNT_WIDTH-1:0]  multiCycles,
    input  logic                  memReady,
    input  logic                  statClear,
    output logic                  pcWE,
    output logic                  ifidWE,
    output logic                  idexWE,
    output logic                  exmemWE,
    output logic                  memwbWE,
    output logic                  ifidFlushN,
    output logic                  idexFlushN,
    output logic                  exmemFlushN,
    output logic                  memwbFlushN,
    output logic                  busy,
    output logic [STAT_WIDTH-1:0] stallCycles
);

    state_t               r_state;
    state_t               w_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [CTL_W-1:0]     r_ctl;
    logic                 r_busy;

    // Next state. In RUN the priority is branch > mem stall > multi > load-use.
    // MULTI counter holds (remaining cycles - 1); exit is decided at zero.
    always_comb begin
        w_next     = ST_RUN;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (branchTaken) begin
                    w_next = ST_REDIRECT;
                end else if (!memReady) begin
                    w_next = ST_MEMWAIT;
                end else if (multiStart) begin
                    w_next     = ST_MULTI;
                    w_cnt_next = (multiCycles == '0) ? '0 : multiCycles - CNT_WIDTH'(1);
                end else if (loadUseHaz) begin
                    w_next = ST_STALL_LU;
                end
            end
            ST_REDIRECT: w_next = ST_RUN;
            ST_STALL_LU: w_next = ST_RUN;
            ST_MULTI: begin
                if (r_cnt == '0) begin
                    w_next = memReady ? ST_RUN : ST_MEMWAIT;
                end else begin
                    w_next     = ST_MULTI;
                    w_cnt_next = r_cnt - CNT_WIDTH'(1);
                end
            end
            ST_MEMWAIT: w_next = memReady ? ST_RUN : ST_MEMWAIT;
            default:    w_next = ST_RUN;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so a request sampled at edge k is visible from edge k on.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_ctl   <= CTL_RESET;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_ctl   <= ctl_of(w_next);
            r_busy  <= (w_next != ST_RUN);
        end
    end

    sat_counter #(
        .WIDTH (STAT_WIDTH)
    ) u_stat (
        .clk     (clk),
        .rst_n   (resetn),
        .i_clear (statClear),
        .i_inc   (r_state != ST_RUN),
        .o_count (stallCycles)
    );

    assign {pcWE, ifidWE, idexWE, exmemWE, memwbWE,
            ifidFlushN, idexFlushN, exmemFlushN, memwbFlushN} = r_ctl;
    assign busy = r_busy;

endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control
//   Scoreboard bench for pipeline_control. Two instances share stimulus:
//   one with the default 16-bit stall counter, one with a 4-bit counter so
//   saturation is reachable quickly. The driver pushes the reference
//   model's expected outputs; a monitor pops and compares after each edge.
module tb_pipeline_control;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       branchTaken = 1'b0;
    logic       loadUseHaz = 1'b0;
    logic       multiStart = 1'b0;
    logic [3:0] multiCycles = 4'd0;
    logic       memReady = 1'b1;
    logic       statClear = 1'b0;

    logic       a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fi, a_fd, a_fe, a_fm, a_busy;
    logic       b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fi, b_fd, b_fe, b_fm, b_busy;
    logic [15:0] a_stat;
    logic [3:0]  b_stat;

    always #5 clk = ~clk;

    pipeline_control #(.CNT_WIDTH(4), .STAT_WIDTH(16)) dut_a (
        .clk(clk), .resetn(resetn), .branchTaken(branchTaken), .loadUseHaz(loadUseHaz),
        .multiStart(multiStart), .multiCycles(multiCycles), .memReady(memReady),
        .statClear(statClear), .pcWE(a_pc), .ifidWE(a_ifid), .idexWE(a_idex),
        .exmemWE(a_exmem), .memwbWE(a_memwb), .ifidFlushN(a_fi), .idexFlushN(a_fd),
        .exmemFlushN(a_fe), .memwbFlushN(a_fm), .busy(a_busy), .stallCycles(a_stat)
    );

    pipeline_control #(.CNT_WIDTH(4), .STAT_WIDTH(4)) dut_b (
        .clk(clk), .resetn(resetn), .branchTaken(branchTaken), .loadUseHaz(loadUseHaz),
        .multiStart(multiStart), .multiCycles(multiCycles), .memReady(memReady),
        .statClear(statClear), .pcWE(b_pc), .ifidWE(b_ifid), .idexWE(b_idex),
        .exmemWE(b_exmem), .memwbWE(b_memwb), .ifidFlushN(b_fi), .idexFlushN(b_fd),
        .exmemFlushN(b_fe), .memwbFlushN(b_fm), .busy(b_busy), .stallCycles(b_stat)
    );

    logic [8:0] ctl_a, ctl_b;
    assign ctl_a = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fi, a_fd, a_fe, a_fm};
    assign ctl_b = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fi, b_fd, b_fe, b_fm};

    typedef struct packed {
        logic [8:0]  ctl;
        logic        busy;
        logic [15:0] s16;
        logic [3:0]  s4;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;

    // Reference model: what the pipe is doing and how many stall cycles remain.
    typedef enum int { M_FLOWING, M_BRANCH_BUBBLE, M_LOADUSE_BUBBLE, M_LONG_OP, M_MEM_FROZEN } mode_t;
    mode_t m_mode = M_FLOWING;
    int    m_left = 0;
    int    m_s16 = 0;
    int    m_s4 = 0;
    bit    m_in_reset = 1'b1;

    function automatic logic [8:0] expect_ctl(input mode_t md);
        logic pc, ifid, idex, exmem, memwb, fi, fd, fe, fm;
        {pc, ifid, idex, exmem, memwb, fi, fd, fe, fm} = 9'h1FF;
        case (md)
            M_BRANCH_BUBBLE:  begin fi = 1'b0; fd = 1'b0; end
            M_LOADUSE_BUBBLE: begin pc = 1'b0; ifid = 1'b0; fd = 1'b0; end
            M_LONG_OP:        begin pc = 1'b0; ifid = 1'b0; idex = 1'b0; exmem = 1'b0; fm = 1'b0; end
            M_MEM_FROZEN:     begin pc = 1'b0; ifid = 1'b0; idex = 1'b0; exmem = 1'b0; memwb = 1'b0; end
            default: ;
        endcase
        return {pc, ifid, idex, exmem, memwb, fi, fd, fe, fm};
    endfunction

    task automatic model_reset();
        m_mode = M_FLOWING; m_left = 0; m_s16 = 0; m_s4 = 0; m_in_reset = 1'b1;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        exp_t e;
        if (!resetn) begin
            model_reset();
        end else begin
            m_in_reset = 1'b0;
            if (statClear) begin
                m_s16 = 0; m_s4 = 0;
            end else if (m_mode != M_FLOWING) begin
                if (m_s16 < 65535) m_s16++;
                if (m_s4 < 15) m_s4++;
            end
            case (m_mode)
                M_FLOWING: begin
                    if (branchTaken)    m_mode = M_BRANCH_BUBBLE;
                    else if (!memReady) m_mode = M_MEM_FROZEN;
                    else if (multiStart) begin
                        m_mode = M_LONG_OP;
                        m_left = (multiCycles == 0) ? 1 : int'(multiCycles);
                    end
                    else if (loadUseHaz) m_mode = M_LOADUSE_BUBBLE;
                end
                M_BRANCH_BUBBLE, M_LOADUSE_BUBBLE: m_mode = M_FLOWING;
                M_LONG_OP: begin
                    m_left--;
                    if (m_left == 0) m_mode = memReady ? M_FLOWING : M_MEM_FROZEN;
                end
                M_MEM_FROZEN: if (memReady) m_mode = M_FLOWING;
                default: m_mode = M_FLOWING;
            endcase
        end
        e.ctl  = m_in_reset ? 9'h000 : expect_ctl(m_mode);
        e.busy = !m_in_reset && (m_mode != M_FLOWING);
        e.s16  = 16'(m_s16);
        e.s4   = 4'(m_s4);
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // Monitor: every edge that has an expectation queued is checked 1ns later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e_mon = q.pop_front();
                chk("ctl_a",  32'(ctl_a),  32'(e_mon.ctl));
                chk("ctl_b",  32'(ctl_b),  32'(e_mon.ctl));
                chk("busy_a", 32'(a_busy), 32'(e_mon.busy));
                chk("busy_b", 32'(b_busy), 32'(e_mon.busy));
                chk("stat16", 32'(a_stat), 32'(e_mon.s16));
                chk("stat4",  32'(b_stat), 32'(e_mon.s4));
            end
        end
    end

    task automatic step(input logic rn, input logic bt, input logic lu, input logic ms,
                        input logic [3:0] mc, input logic mr, input logic sc);
        @(negedge clk);
        resetn = rn; branchTaken = bt; loadUseHaz = lu; multiStart = ms;
        multiCycles = mc; memReady = mr; statClear = sc;
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    // Drop reset between edges and check outputs clear with no clock edge.
    task automatic async_reset_pulse();
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_ctl",  32'(ctl_a),  32'h0);
        chk("arst_busy", 32'(a_busy), 32'h0);
        chk("arst_stat", 32'(a_stat), 32'h0);
        model_reset();
    endtask

    initial begin
        // Reset held for 3 edges, then release.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(2);
        // Taken branch.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(2);
        // Load-use stall, then repeated request ignored in the bubble.
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(2);
        // Multi-cycle op of 3, requests ignored inside.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0);
        idle(4);
        // multiCycles = 0 -> single stall cycle.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        idle(2);
        // Simultaneous multiStart + branchTaken -> redirect only.
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0);
        idle(2);
        // Multi of 2, memReady low for 4 edges from the closing edge.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
        idle(1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        idle(2);
        // Async reset in the middle of a long op.
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
        idle(1);
        async_reset_pulse();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        idle(2);
        // Saturation of the 4-bit counter, then clear.
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        idle(2);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 10),
                 4'($urandom_range(0, 5)),
                 ($urandom_range(0, 99) >= 15),
                 ($urandom_range(0, 99) < 3));
        end
        idle(1);
        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #3;
        chk("drain", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
